// File: rtl/score_glyph_renderer.sv
// Score renderer: latch a binary score, double-dabble it to BCD, then stream 8x8 glyph pixels (scale 1/2/4/8).
// Latency: first pixel SCORE_W+1 cycles after the accepted start; then one pixel per non-stalled cycle.
// Backpressure: stall freezes the pixel counters and holds pix_* stable. Option macro: SCORE_LEADING_ZEROS_EN.
module score_glyph_renderer #(
  parameter  int NUM_DIGITS = 4,
  parameter  int SCORE_W    = 14,
  localparam int X_W        = $clog2(NUM_DIGITS*64)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  input  logic [1:0]         scale_log2,
  input  logic               stall,
  output logic               busy,
  output logic               pix_valid,
  output logic [X_W-1:0]     pix_x,
  output logic [5:0]         pix_y,
  output logic               pix_on,
  output logic               overflow,
  output logic               done
);
  localparam int BCD_W = NUM_DIGITS*4;
  localparam int DC_W  = $clog2(NUM_DIGITS+1);
  localparam int CW    = $clog2(SCORE_W+1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DRAW, ST_FIN} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_armed;
  logic [SCORE_W-1:0] r_sr;
  logic [BCD_W-1:0]   r_bcd, w_bcd_adj, w_bcd_step, w_bcd_final;
  logic               w_carry;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_s;
  logic               r_ovf;
  logic [DC_W-1:0]    r_nd, w_nd, r_digit, w_sel;
  logic [5:0]         r_x, r_y, w_xmax;
  logic               w_accept, w_last_conv, w_last_x, w_last_y, w_last_pix;
  logic [3:0]         w_code;
  logic [63:0]        w_glyph;
  logic [2:0]         w_row, w_col;
  logic [X_W-1:0]     w_px;

  // 8x8 font, bit 63 = top-left; row 0 is the most significant byte
  function automatic logic [63:0] glyph_rom(input logic [3:0] code);
    case (code)
      4'd0:    glyph_rom = 64'h3C666E7666663C00;
      4'd1:    glyph_rom = 64'h1838181818187E00;
      4'd2:    glyph_rom = 64'h3C66060C30607E00;
      4'd3:    glyph_rom = 64'h3C66061C06663C00;
      4'd4:    glyph_rom = 64'h0C1C3C6C7E0C0C00;
      4'd5:    glyph_rom = 64'h7E607C0606663C00;
      4'd6:    glyph_rom = 64'h3C607C6666663C00;
      4'd7:    glyph_rom = 64'h7E060C1830303000;
      4'd8:    glyph_rom = 64'h3C66663C66663C00;
      4'd9:    glyph_rom = 64'h3C66663E060C3800;
      default: glyph_rom = 64'h0;
    endcase
  endfunction

  // start is only honoured once reset has been released for a full cycle
  assign w_accept    = start && r_armed;
  assign w_last_conv = (r_cnt == CW'(SCORE_W-1));

  // double-dabble add-3 correction on every BCD digit before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_carry     = w_bcd_adj[BCD_W-1];
  assign w_bcd_step  = {w_bcd_adj[BCD_W-2:0], r_sr[SCORE_W-1]};
  assign w_bcd_final = (r_ovf || w_carry) ? {NUM_DIGITS{4'h9}} : w_bcd_step;

  // drawn digit count from the final BCD value
  always_comb begin
    w_nd = DC_W'(1);
`ifdef SCORE_LEADING_ZEROS_EN
    w_nd = DC_W'(NUM_DIGITS);
`else
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_bcd_final[4*k +: 4] != 4'd0) w_nd = DC_W'(k+1);
    end
`endif
  end

  // pixel-counter limits for the latched scale
  always_comb begin
    case (r_s)
      2'd0:    w_xmax = 6'd7;
      2'd1:    w_xmax = 6'd15;
      2'd2:    w_xmax = 6'd31;
      default: w_xmax = 6'd63;
    endcase
  end

  assign w_last_x   = (r_x == w_xmax);
  assign w_last_y   = (r_y == w_xmax);
  assign w_last_pix = w_last_x && w_last_y && (r_digit == r_nd - 1'b1);

  // glyph lookup: leftmost drawn digit is BCD digit nd-1
  assign w_sel   = r_nd - r_digit - 1'b1;
  assign w_code  = 4'(r_bcd >> {w_sel, 2'b00});
  assign w_glyph = glyph_rom(w_code);
  assign w_row   = 3'(r_y >> r_s);
  assign w_col   = 3'(r_x >> r_s);
  assign w_px    = (X_W'(r_digit) << (3 + r_s)) + X_W'(r_x);

  assign pix_x    = pix_valid ? w_px : '0;
  assign pix_y    = pix_valid ? r_y  : '0;
  assign pix_on   = pix_valid ? w_glyph[{~w_row, ~w_col}] : 1'b0;
  assign overflow = r_ovf;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    pix_valid   = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CONV;
      ST_CONV: begin
        busy = 1'b1;
        if (w_last_conv) w_state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        if (!stall && w_last_pix) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // datapath: score latch, conversion, and pixel scan counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_armed <= 1'b0;
      r_sr    <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_ovf   <= 1'b0;
      r_nd    <= '0;
      r_digit <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_sr  <= score;
          r_s   <= scale_log2;
          r_ovf <= 1'b0;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        ST_CONV: begin
          r_sr  <= r_sr << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_carry) r_ovf <= 1'b1;
          if (w_last_conv) begin
            r_bcd   <= w_bcd_final;
            r_nd    <= w_nd;
            r_digit <= '0;
            r_x     <= '0;
            r_y     <= '0;
          end else begin
            r_bcd <= w_bcd_step;
          end
        end
        ST_DRAW: if (!stall) begin
          if (w_last_x) begin
            r_x <= '0;
            if (w_last_y) begin
              r_y     <= '0;
              r_digit <= r_digit + 1'b1;
            end else begin
              r_y <= r_y + 6'd1;
            end
          end else begin
            r_x <= r_x + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_score_glyph_renderer.sv
module tb_score_glyph_renderer;
  localparam int N  = 4;
  localparam int SW = 14;
  localparam int XW = $clog2(N*64);

  logic          clk = 1'b0;
  logic          resetn, start, stall;
  logic [SW-1:0] score;
  logic [1:0]    scale_log2;
  logic          busy, pix_valid, pix_on, overflow, done;
  logic [XW-1:0] pix_x;
  logic [5:0]    pix_y;

  always #5 clk = ~clk;

  score_glyph_renderer #(.NUM_DIGITS(N), .SCORE_W(SW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .score(score), .scale_log2(scale_log2),
    .stall(stall), .busy(busy), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_on(pix_on), .overflow(overflow), .done(done)
  );

  typedef struct {int x; int y; bit on;} pix_t;
  typedef struct {bit ovf; int npix; bit timed;} job_t;

  pix_t exp_q[$];
  job_t job_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_pix_cnt = 0;
  bit   m_done_seen = 0;

  // font rows, MSB of each byte is the leftmost column
  byte unsigned font [10][8] = '{
    '{8'h3C,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h3C,8'h00},
    '{8'h18,8'h38,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00},
    '{8'h3C,8'h66,8'h06,8'h0C,8'h30,8'h60,8'h7E,8'h00},
    '{8'h3C,8'h66,8'h06,8'h1C,8'h06,8'h66,8'h3C,8'h00},
    '{8'h0C,8'h1C,8'h3C,8'h6C,8'h7E,8'h0C,8'h0C,8'h00},
    '{8'h7E,8'h60,8'h7C,8'h06,8'h06,8'h66,8'h3C,8'h00},
    '{8'h3C,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h3C,8'h00},
    '{8'h7E,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h00},
    '{8'h3C,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h3C,8'h00},
    '{8'h3C,8'h66,8'h66,8'h3E,8'h06,8'h0C,8'h38,8'h00}
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // reference model: decimal digits of the (saturated) score drawn from the font table
  task automatic push_job(input int sc, input int s, input bit timed);
    int lim, v, nd, t, sz, p, dig, row;
    bit ovf;
    lim = 1;
    for (int i = 0; i < N; i++) lim *= 10;
    ovf = (sc > lim - 1);
    v   = ovf ? lim - 1 : sc;
    nd  = 1;
    t   = v / 10;
    while (t > 0) begin nd++; t /= 10; end
`ifdef SCORE_LEADING_ZEROS_EN
    nd = N;
`endif
    sz = 8 << s;
    for (int d = 0; d < nd; d++) begin
      p = 1;
      for (int k = 0; k < nd - 1 - d; k++) p *= 10;
      dig = (v / p) % 10;
      for (int y = 0; y < sz; y++) begin
        row = font[dig][y >> s];
        for (int x = 0; x < sz; x++)
          exp_q.push_back('{d*sz + x, y, bit'((row >> (7 - (x >> s))) & 1)});
      end
    end
    job_q.push_back('{ovf, nd*sz*sz, timed});
  endtask

  // monitor: pops expected pixels on every accepted pixel and checks job boundaries
  initial begin
    bit   in_job, prev_busy, was_stall, seen_pix;
    int   cyc;
    job_t cj;
    pix_t e;
    logic [XW+6:0] held;
    in_job = 0; prev_busy = 0; was_stall = 0; seen_pix = 0; cyc = 0;
    cj = '{0, 0, 0};
    held = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_job = 0; prev_busy = 0; was_stall = 0;
        continue;
      end
      if (busy && !prev_busy) begin
        if (job_q.size() == 0) fail("unexpected_job_start");
        else cj = job_q.pop_front();
        in_job = 1; cyc = 1; seen_pix = 0; m_pix_cnt = 0; was_stall = 0;
      end else if (in_job) begin
        cyc++;
      end
      prev_busy = busy;
      if (pix_valid) begin
        if (!seen_pix) begin
          seen_pix = 1;
          check("first_pixel_cycle", 64'(cyc), 64'(SW + 1));
        end
        if (was_stall) check("stall_hold", 64'({pix_x, pix_y, pix_on}), 64'(held));
        if (stall) begin
          was_stall = 1;
          held = {pix_x, pix_y, pix_on};
        end else begin
          was_stall = 0;
          if (exp_q.size() == 0) fail("extra_pixel");
          else begin
            e = exp_q.pop_front();
            check("pixel", 64'({pix_x, pix_y, pix_on}), 64'({XW'(e.x), 6'(e.y), e.on}));
          end
          m_pix_cnt++;
        end
      end
      if (done) begin
        check("done_busy", 64'(busy), 64'(1));
        check("overflow", 64'(overflow), 64'(cj.ovf));
        check("pixel_count", 64'(m_pix_cnt), 64'(cj.npix));
        if (cj.timed) check("done_cycle", 64'(cyc), 64'(SW + 1 + cj.npix));
        in_job = 0;
        m_done_seen = 1;
      end
    end
  end

  // mode: 0 no stall, 1 random stall, 2 stall 5 cycles at pixel 70, 3 start during DRAW, 4 reset mid-DRAW
  task automatic run_job(input int sc, input int s, input int mode);
    int stall_left;
    bit stalled_once, poked;
    stall_left = 0; stalled_once = 0; poked = 0;
    push_job(sc, s, (mode == 0) || (mode == 3));
    m_done_seen = 0;
    @(posedge clk); #1;
    score = SW'(sc); scale_log2 = 2'(s); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; score = SW'($urandom); scale_log2 = 2'($urandom);
    for (int c = 0; c < 30000 && !m_done_seen; c++) begin
      case (mode)
        1: stall = ($urandom_range(0, 3) == 0);
        2: begin
          if (!stalled_once && pix_valid && m_pix_cnt == 70) begin
            stalled_once = 1; stall_left = 5;
          end
          stall = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        3: begin
          if (!poked && pix_valid && m_pix_cnt == 20) begin
            start = 1'b1; score = SW'(1); poked = 1;
          end else start = 1'b0;
        end
        4: if (pix_valid && m_pix_cnt == 50) begin
          resetn = 1'b0;
          #1;
          check("reset_mid_draw", 64'({busy, pix_valid, pix_x, pix_y, pix_on, overflow, done}), 64'(0));
          exp_q.delete();
          job_q.delete();
          repeat (2) @(negedge clk);
          resetn = 1'b1;
          repeat (2) @(posedge clk);
          return;
        end
        default: stall = 1'b0;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
    if (!m_done_seen) fail("job_timeout");
    @(posedge clk); #1;
    check("idle_after_done", 64'({busy, done, pix_valid}), 64'(0));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stall = 1'b0; score = '0; scale_log2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, pix_valid, pix_x, pix_y, pix_on, overflow, done}), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    run_job(0, 0, 0);
    run_job(907, 1, 0);
    run_job(12345, 0, 0);
    run_job(42, 0, 2);
    run_job(5000, 0, 3);
    run_job(12345, 1, 4);
    run_job(7, 0, 0);
    run_job(9999, 0, 0);
    run_job(10000, 0, 1);
    run_job(8, 3, 1);
    for (int i = 0; i < 6; i++)
      run_job(int'($urandom_range(0, 16383)), int'($urandom_range(0, 2)), 1);

    check("leftover_pixels", 64'(exp_q.size()), 64'(0));
    check("leftover_jobs", 64'(job_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
